ecg_usb_ctrl_regs: RTL and testbench
====================================

# ecg_usb_ctrl_regs

Register bank sitting directly downstream of `cw305_usb_reg_fe` on `usb_clk_buf`. It decodes the front-end's address, byte-count and strobe outputs, and holds control and configuration for the ECG core. It generates start and reset pulses toward the core and returns synchronized handshake status plus a handshake event counter on the read-data bus. It replaces ad-hoc wiring of `write_data` bits to `btnC`/`btnU`.

## Interface
- `pBYTECNT_SIZE`, 7, byte-count width (matches front-end)
- `pADDR_WIDTH`, 21, USB address width; register address width is `pADDR_WIDTH-pBYTECNT_SIZE` (14)
- `pRST_CYCLES`, 16, length of `core_rst` pulse in clocks (≥1)
- `usb_clk` in 1: single clock, buffered USB clock
- `rst` in 1: reset, synchronous, active-high
- `reg_address` in 14: register address from front-end
- `reg_bytecnt` in 7: byte index within register
- `reg_datai` in 8: write data (front-end `reg_datao`)
- `reg_datao` out 8: read data (front-end `reg_datai`)
- `reg_read` in 1: read strobe
- `reg_write` in 1: write strobe, one cycle per byte
- `reg_addrvalid` in 1: address/bytecnt valid
- `hs_status` in 4: {w_ack, w_req, r_ack, r_req}, asynchronous to `usb_clk`
- `core_done` in 1: asynchronous done level from core
- `core_start` out 1: one-cycle start pulse
- `core_rst` out 1: active-high core reset pulse
- `core_en` out 1: enable level
- `core_cfg` out 32: configuration word

## Operation
- Register map; accesses with `reg_addrvalid`=0 are ignored:
  - 0x00 ID, RO, 1 byte: 0xEC.
  - 0x01 CTRL, byte 0:
    - Write bit0=1 → `core_start` pulse.
    - Write bit1=1 → `core_rst` pulse.
    - Bit2 = `core_en`, RW.
    - Read returns {5'b0, `core_en`, 2'b0}.
  - 0x02 STATUS, byte 0:
    - Read returns {2'b0, rst_busy, done_sticky, hs_sync[3:0]}.
    - Write bit4=1 clears done_sticky.
  - 0x03 CONFIG, bytes 0–3, little-endian, RW, drives `core_cfg`. Bytecnt ≥4: writes ignored, reads 0.
  - 0x04 HSCOUNT, bytes 0–1, RO counter of rising edges of synchronized w_ack. Saturates at 0xFFFF. Any write clears it.
  - Unmapped address or bytecnt: reads 0x00, writes ignored.
- `hs_status` and `core_done` pass through a 2-flop synchronizer. Edge detection of w_ack and `core_done` uses the synchronized value and its 1-cycle delayed copy.
- done_sticky: set on rising edge of synchronized done. If set and clear occur in the same cycle, set wins.
- HSCOUNT coherency:
  - A read (`reg_read`=1) of bytecnt 0 copies the live counter into a 16-bit snapshot and returns its low byte.
  - Bytecnt 1 returns the snapshot high byte.
  - If clear and increment occur in the same cycle, clear wins (result 0).
- `core_rst` pulse:
  - Down-counter loaded with `pRST_CYCLES`; `core_rst`=1 while the counter is non-zero.
  - A re-write during the pulse reloads the counter (pulse extends).
  - rst_busy = `core_rst`.
- Start write while `core_rst`=1: `core_start` is suppressed (no pulse, no pending).
- Start and reset bits both set in one write: reset takes effect, start is suppressed.

## Timing
- Reset values:
  - `reg_datao`=0, `core_start`=0, `core_rst`=0, `core_en`=0, `core_cfg`=0.
  - Sticky, counter, snapshot, and synchronizer flops = 0.
- Writes: register updates on the clock edge where `reg_write`=1. Outputs reflect the new value the next cycle.
- `core_start`: high exactly one cycle, the cycle after the write edge.
- `core_rst`: high for exactly `pRST_CYCLES` cycles, starting the cycle after the write edge.
- `reg_datao`: registered mux of `reg_address`/`reg_bytecnt`. Valid 1 cycle after address/bytecnt are stable, independent of `reg_read`. The snapshot path returns the captured value in that same 1-cycle latency.
- Status latency: an input edge is visible in STATUS 3 cycles later (2 sync + 1 output register). The counter increments 3 cycles after the w_ack edge.
- `rst` asserted mid-pulse: `core_rst` drops the next cycle. Assert `rst` to the core separately if required.

## Structure
- Package `ecg_usb_regs_pkg`:
  - Address constants ADDR_ID…ADDR_HSCOUNT.
  - ID_VALUE=8'hEC.
  - CTRL/STATUS bit indices.
  - Data width 8.
- Sub-module `ecg_sync2`: parameterized-width 2-flop synchronizer with synchronous reset, instantiated once (width 5).
- Top-level instantiation: between `cw305_usb_reg_fe` and `basys3_top`, same `usb_clk_buf` and `reset`.

## Test plan
- Reset, then read 0x00, 0x01, 0x03 bytes 0–3 → 0xEC, 0x00, 0x00×4.
- Write CONFIG bytes 0–3 = 0x78,0x56,0x34,0x12, then write bytecnt 4 = 0xFF → `core_cfg`=0x12345678; reading bytecnt 4 returns 0x00.
- Write CTRL=0x01 → `core_start` high exactly 1 cycle. Write CTRL=0x02 → `core_rst` high 16 cycles. Re-write 0x02 at cycle 10 → total 26 cycles. Write 0x03 → no `core_start`.
- Toggle async w_ack 5 times → HSCOUNT=5, visible 3 cycles after the last edge. Between the byte 0 and byte 1 reads, pulse w_ack 256 more times → byte 1 still reads 0x00. Preload to 0xFFFF → stays 0xFFFF.
- Pulse `core_done` → STATUS bit4=1. Write STATUS 0x10 on the same cycle as a new done edge → bit4 stays 1. Write 0x10 alone → bit4=0.
- Assert `rst` at cycle 5 of a `core_rst` pulse and with `core_en`=1 → next cycle `core_rst`=0, `core_en`=0, HSCOUNT=0.

Source files
------------

// File: rtl/ecg_usb_regs_pkg.sv
// Shared register-map constants and decode types for the ECG USB control
// register bank.
package ecg_usb_regs_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_ADDR_W = 14;

  localparam logic [REG_ADDR_W-1:0] ADDR_ID      = 14'h0000;
  localparam logic [REG_ADDR_W-1:0] ADDR_CTRL    = 14'h0001;
  localparam logic [REG_ADDR_W-1:0] ADDR_STATUS  = 14'h0002;
  localparam logic [REG_ADDR_W-1:0] ADDR_CONFIG  = 14'h0003;
  localparam logic [REG_ADDR_W-1:0] ADDR_HSCOUNT = 14'h0004;

  localparam logic [DATA_W-1:0] ID_VALUE = 8'hEC;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_RST_BIT    = 1;
  localparam int unsigned CTRL_EN_BIT     = 2;
  localparam int unsigned STATUS_DONE_BIT = 4;
  localparam int unsigned STATUS_BUSY_BIT = 5;
  localparam int unsigned HS_W_ACK_BIT    = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ID,
    SEL_CTRL,
    SEL_STATUS,
    SEL_CONFIG,
    SEL_HSCOUNT
  } reg_sel_e;

endpackage

// File: rtl/ecg_sync2.sv
// Two-flop synchronizer for slow level signals crossing into the USB clock
// domain; each bit is synchronized independently.
module ecg_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, forming a true two-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ecg_usb_ctrl_regs.sv
// Register bank behind the CW305 USB front-end: control/config for the ECG
// core, start/reset pulse generation, and synchronized handshake status.
module ecg_usb_ctrl_regs
  import ecg_usb_regs_pkg::*;
#(
  parameter int unsigned pBYTECNT_SIZE = 7,
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pRST_CYCLES   = 16
) (
  input  logic                                 usb_clk,
  input  logic                                 rst,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           reg_datai,
  output logic [7:0]                           reg_datao,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  input  logic [3:0]                           hs_status,
  input  logic                                 core_done,
  output logic                                 core_start,
  output logic                                 core_rst,
  output logic                                 core_en,
  output logic [31:0]                          core_cfg
);

  localparam int unsigned RA_W = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int unsigned RC_W = $clog2(pRST_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(pRST_CYCLES);

  logic [4:0] async_in;
  logic [4:0] sync_out;
  logic [3:0] hs_sync;
  logic       done_sync;

  assign async_in = {core_done, hs_status};

  ecg_sync2 #(.WIDTH(5)) u_sync (
    .clk (usb_clk),
    .rst (rst),
    .d_i (async_in),
    .q_o (sync_out)
  );

  assign hs_sync   = sync_out[3:0];
  assign done_sync = sync_out[4];

  logic             w_ack_dly_q, done_dly_q;
  logic             start_q, start_d;
  logic             en_q, en_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             done_sticky_q, done_sticky_d;
  logic [31:0]      cfg_q, cfg_d;
  logic [15:0]      hs_cnt_q, hs_cnt_d;
  logic [15:0]      snap_q, snap_d;
  logic [7:0]       datao_q, datao_d;

  reg_sel_e sel;
  logic     byte0, byte1, cfg_byte_ok;
  logic     wr_en, rd_en;
  logic     wr_ctrl, wr_status, wr_cfg, wr_hs;
  logic     w_ack_rise, done_rise;
  logic     rst_busy;

  assign w_ack_rise = hs_sync[HS_W_ACK_BIT] & ~w_ack_dly_q;
  assign done_rise  = done_sync & ~done_dly_q;
  assign rst_busy   = (rst_cnt_q != '0);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case/if structure can leave it unassigned (no latches).
  always_comb begin
    sel = SEL_NONE;
    if (reg_addrvalid) begin
      case (reg_address)
        RA_W'(ADDR_ID):      sel = SEL_ID;
        RA_W'(ADDR_CTRL):    sel = SEL_CTRL;
        RA_W'(ADDR_STATUS):  sel = SEL_STATUS;
        RA_W'(ADDR_CONFIG):  sel = SEL_CONFIG;
        RA_W'(ADDR_HSCOUNT): sel = SEL_HSCOUNT;
        default:             sel = SEL_NONE;
      endcase
    end
  end

  assign byte0       = (reg_bytecnt == '0);
  assign byte1       = (reg_bytecnt == pBYTECNT_SIZE'(1));
  assign cfg_byte_ok = (reg_bytecnt < pBYTECNT_SIZE'(4));
  assign wr_en       = reg_write & reg_addrvalid;
  assign rd_en       = reg_read & reg_addrvalid;
  assign wr_ctrl     = wr_en & (sel == SEL_CTRL) & byte0;
  assign wr_status   = wr_en & (sel == SEL_STATUS) & byte0;
  assign wr_cfg      = wr_en & (sel == SEL_CONFIG) & cfg_byte_ok;
  assign wr_hs       = wr_en & (sel == SEL_HSCOUNT);

  always_comb begin
    en_d          = en_q;
    start_d       = 1'b0;
    rst_cnt_d     = rst_cnt_q;
    done_sticky_d = done_sticky_q;
    cfg_d         = cfg_q;
    hs_cnt_d      = hs_cnt_q;
    snap_d        = snap_q;

    if (wr_ctrl) begin
      en_d = reg_datai[CTRL_EN_BIT];
    end

    // A reset request, or a reset already in progress, swallows any start.
    start_d = wr_ctrl & reg_datai[CTRL_START_BIT] & ~reg_datai[CTRL_RST_BIT] & ~rst_busy;

    if (wr_ctrl && reg_datai[CTRL_RST_BIT]) begin
      rst_cnt_d = RST_LOAD;
    end else if (rst_busy) begin
      rst_cnt_d = rst_cnt_q - 1'b1;
    end

    if (done_rise) begin
      done_sticky_d = 1'b1;
    end else if (wr_status && reg_datai[STATUS_DONE_BIT]) begin
      done_sticky_d = 1'b0;
    end

    if (wr_cfg) begin
      cfg_d[8*int'(reg_bytecnt[1:0]) +: 8] = reg_datai;
    end

    if (wr_hs) begin
      hs_cnt_d = '0;
    end else if (w_ack_rise && hs_cnt_q != 16'hFFFF) begin
      hs_cnt_d = hs_cnt_q + 16'd1;
    end

    // Reading the low byte freezes the whole count so the high byte matches.
    if (rd_en && sel == SEL_HSCOUNT && byte0) begin
      snap_d = hs_cnt_q;
    end
  end

  always_comb begin
    datao_d = '0;
    case (sel)
      SEL_ID:      if (byte0) datao_d = ID_VALUE;
      SEL_CTRL:    if (byte0) datao_d[CTRL_EN_BIT] = en_q;
      SEL_STATUS:  if (byte0) datao_d = {2'b00, rst_busy, done_sticky_q, hs_sync};
      SEL_CONFIG:  if (cfg_byte_ok) datao_d = cfg_q[8*int'(reg_bytecnt[1:0]) +: 8];
      SEL_HSCOUNT: begin
        if (byte0)      datao_d = hs_cnt_q[7:0];
        else if (byte1) datao_d = snap_q[15:8];
      end
      default:     datao_d = '0;
    endcase
  end

  // NOTE: every flop here, including the snapshot and counters, has a reset
  // value; the bank is small and software expects a known state after reset.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      w_ack_dly_q   <= 1'b0;
      done_dly_q    <= 1'b0;
      start_q       <= 1'b0;
      en_q          <= 1'b0;
      rst_cnt_q     <= '0;
      done_sticky_q <= 1'b0;
      cfg_q         <= '0;
      hs_cnt_q      <= '0;
      snap_q        <= '0;
      datao_q       <= '0;
    end else begin
      w_ack_dly_q   <= hs_sync[HS_W_ACK_BIT];
      done_dly_q    <= done_sync;
      start_q       <= start_d;
      en_q          <= en_d;
      rst_cnt_q     <= rst_cnt_d;
      done_sticky_q <= done_sticky_d;
      cfg_q         <= cfg_d;
      hs_cnt_q      <= hs_cnt_d;
      snap_q        <= snap_d;
      datao_q       <= datao_d;
    end
  end

  assign reg_datao  = datao_q;
  assign core_start = start_q;
  assign core_rst   = rst_busy;
  assign core_en    = en_q;
  assign core_cfg   = cfg_q;

endmodule

// File: tb/tb_ecg_usb_ctrl_regs.sv
// Directed bench for ecg_usb_ctrl_regs: table of register accesses followed
// by hand-timed sequences for pulses, synchronizer latency and counters.
module tb_ecg_usb_ctrl_regs;
  import ecg_usb_regs_pkg::*;

  logic        usb_clk;
  logic        rst;
  logic [13:0] reg_address;
  logic [6:0]  reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [3:0]  hs_status;
  logic        core_done;
  logic        core_start;
  logic        core_rst;
  logic        core_en;
  logic [31:0] core_cfg;

  int n_vec;
  int n_err;

  ecg_usb_ctrl_regs #(
    .pBYTECNT_SIZE (7),
    .pADDR_WIDTH   (21),
    .pRST_CYCLES   (16)
  ) dut (
    .usb_clk       (usb_clk),
    .rst           (rst),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .reg_datai     (reg_datai),
    .reg_datao     (reg_datao),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .hs_status     (hs_status),
    .core_done     (core_done),
    .core_start    (core_start),
    .core_rst      (core_rst),
    .core_en       (core_en),
    .core_cfg      (core_cfg)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [6:0]  cnt;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks are entered on a falling edge and return on a falling edge.
  task automatic do_write(input logic [13:0] a, input logic [6:0] c, input logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = c;
    reg_datai     = d;
    reg_addrvalid = 1'b1;
    reg_write     = 1'b1;
    @(negedge usb_clk);
    reg_write     = 1'b0;
  endtask

  task automatic do_read(input logic [13:0] a, input logic [6:0] c, output logic [7:0] d);
    reg_address   = a;
    reg_bytecnt   = c;
    reg_addrvalid = 1'b1;
    reg_read      = 1'b1;
    @(negedge usb_clk);
    d        = reg_datao;
    reg_read = 1'b0;
  endtask

  task automatic count_rst(output int n);
    n = 0;
    while (core_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge usb_clk);
    end
  endtask

  task automatic pulse_w_ack(input int times);
    for (int i = 0; i < times; i++) begin
      hs_status[HS_W_ACK_BIT] = 1'b1;
      repeat (2) @(negedge usb_clk);
      hs_status[HS_W_ACK_BIT] = 1'b0;
      repeat (2) @(negedge usb_clk);
    end
  endtask

  vec_t vecs[$];
  logic [7:0] rd;
  int   n1, n2, k;
  logic seen;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    reg_address   = '0;
    reg_bytecnt   = '0;
    reg_datai     = '0;
    reg_read      = 1'b0;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
    hs_status     = '0;
    core_done     = 1'b0;

    vecs.push_back('{1'b0, ADDR_ID,      7'd0, 8'h00, 8'hEC});
    vecs.push_back('{1'b0, ADDR_CTRL,    7'd0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd1, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd2, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd3, 8'h00, 8'h00});
    vecs.push_back('{1'b1, ADDR_CONFIG,  7'd0, 8'h78, 8'h00});
    vecs.push_back('{1'b1, ADDR_CONFIG,  7'd1, 8'h56, 8'h00});
    vecs.push_back('{1'b1, ADDR_CONFIG,  7'd2, 8'h34, 8'h00});
    vecs.push_back('{1'b1, ADDR_CONFIG,  7'd3, 8'h12, 8'h00});
    vecs.push_back('{1'b1, ADDR_CONFIG,  7'd4, 8'hFF, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd4, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd0, 8'h00, 8'h78});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd2, 8'h00, 8'h34});
    vecs.push_back('{1'b0, ADDR_CONFIG,  7'd3, 8'h00, 8'h12});
    vecs.push_back('{1'b1, ADDR_ID,      7'd0, 8'h55, 8'h00});
    vecs.push_back('{1'b0, ADDR_ID,      7'd0, 8'h00, 8'hEC});
    vecs.push_back('{1'b0, 14'h0005,     7'd0, 8'h00, 8'h00});
    vecs.push_back('{1'b1, ADDR_CTRL,    7'd0, 8'h04, 8'h00});
    vecs.push_back('{1'b0, ADDR_CTRL,    7'd0, 8'h00, 8'h04});
    vecs.push_back('{1'b0, ADDR_CTRL,    7'd1, 8'h00, 8'h00});
    vecs.push_back('{1'b1, ADDR_CTRL,    7'd0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, ADDR_CTRL,    7'd0, 8'h00, 8'h00});

    repeat (3) @(negedge usb_clk);
    check("reset core_start", 32'(core_start), 32'd0);
    check("reset core_rst",   32'(core_rst),   32'd0);
    check("reset core_en",    32'(core_en),    32'd0);
    check("reset core_cfg",   core_cfg,        32'd0);
    check("reset reg_datao",  32'(reg_datao),  32'd0);
    rst = 1'b0;
    @(negedge usb_clk);

    // Table of register reads and writes.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].cnt, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, vecs[i].cnt, rd);
        check($sformatf("vec %0d read a=%0h b=%0d", i, vecs[i].addr, vecs[i].cnt),
              32'(rd), 32'(vecs[i].exp));
      end
    end
    check("core_cfg after config writes", core_cfg, 32'h12345678);

    // Start pulse: exactly one cycle, the cycle after the write edge.
    check("start idle before write", 32'(core_start), 32'd0);
    do_write(ADDR_CTRL, 7'd0, 8'h01);
    check("start high cycle 1", 32'(core_start), 32'd1);
    @(negedge usb_clk);
    check("start low cycle 2", 32'(core_start), 32'd0);

    // Reset pulse length.
    do_write(ADDR_CTRL, 7'd0, 8'h02);
    count_rst(n1);
    check("core_rst pulse length", 32'(n1), 32'd16);

    // Re-write on the 10th cycle of the pulse extends it to 10+16.
    do_write(ADDR_CTRL, 7'd0, 8'h02);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_rst === 1'b1) k++;
      if (i < 9) @(negedge usb_clk);
    end
    do_write(ADDR_CTRL, 7'd0, 8'h02);
    count_rst(n2);
    check("core_rst extended length", 32'(k + n2), 32'd26);

    // Start write during an active reset pulse is dropped.
    do_write(ADDR_CTRL, 7'd0, 8'h02);
    do_write(ADDR_CTRL, 7'd0, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (core_start === 1'b1) seen = 1'b1;
      @(negedge usb_clk);
    end
    check("start suppressed during core_rst", 32'(seen), 32'd0);
    count_rst(n1);

    // Start and reset together: reset only.
    do_write(ADDR_CTRL, 7'd0, 8'h03);
    check("ctrl 0x03 core_rst", 32'(core_rst), 32'd1);
    seen = core_start;
    for (int i = 0; i < 3; i++) begin
      @(negedge usb_clk);
      if (core_start === 1'b1) seen = 1'b1;
    end
    check("ctrl 0x03 no start", 32'(seen), 32'd0);
    count_rst(n1);
    check("ctrl 0x03 core_rst length", 32'(n1 + 3), 32'd16);

    // STATUS latency: an input change appears on reg_datao 3 cycles later.
    reg_address = ADDR_STATUS;
    reg_bytecnt = 7'd0;
    repeat (2) @(negedge usb_clk);
    hs_status = 4'b0101;
    repeat (2) @(negedge usb_clk);
    check("status hs before latency", 32'(reg_datao), 32'h00);
    @(negedge usb_clk);
    check("status hs after 3 cycles", 32'(reg_datao), 32'h05);
    hs_status = 4'b0000;
    repeat (4) @(negedge usb_clk);

    // Handshake counter and snapshot coherency.
    pulse_w_ack(5);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("hscount byte0 after 5", 32'(rd), 32'h05);
    pulse_w_ack(256);
    do_read(ADDR_HSCOUNT, 7'd1, rd);
    check("hscount byte1 from snapshot", 32'(rd), 32'h00);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("hscount byte0 after 261", 32'(rd), 32'h05);
    do_read(ADDR_HSCOUNT, 7'd1, rd);
    check("hscount byte1 after 261", 32'(rd), 32'h01);

    do_write(ADDR_HSCOUNT, 7'd1, 8'h00);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("hscount cleared byte0", 32'(rd), 32'h00);
    do_read(ADDR_HSCOUNT, 7'd1, rd);
    check("hscount cleared byte1", 32'(rd), 32'h00);

    // Clear on the same edge as an increment: clear wins.
    hs_status[HS_W_ACK_BIT] = 1'b1;
    repeat (2) @(negedge usb_clk);
    do_write(ADDR_HSCOUNT, 7'd0, 8'h00);
    hs_status[HS_W_ACK_BIT] = 1'b0;
    repeat (3) @(negedge usb_clk);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("hscount clear beats increment", 32'(rd), 32'h00);

    // Saturation at 0xFFFF.
    force dut.hs_cnt_q = 16'hFFFF;
    @(negedge usb_clk);
    release dut.hs_cnt_q;
    pulse_w_ack(1);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("hscount saturated byte0", 32'(rd), 32'hFF);
    do_read(ADDR_HSCOUNT, 7'd1, rd);
    check("hscount saturated byte1", 32'(rd), 32'hFF);

    // done_sticky: set, clear, and set winning over a same-edge clear.
    core_done = 1'b1;
    repeat (4) @(negedge usb_clk);
    core_done = 1'b0;
    repeat (4) @(negedge usb_clk);
    do_read(ADDR_STATUS, 7'd0, rd);
    check("status done sticky set", 32'(rd), 32'h10);
    do_write(ADDR_STATUS, 7'd0, 8'h10);
    do_read(ADDR_STATUS, 7'd0, rd);
    check("status done sticky cleared", 32'(rd), 32'h00);
    core_done = 1'b1;
    repeat (2) @(negedge usb_clk);
    do_write(ADDR_STATUS, 7'd0, 8'h10);
    do_read(ADDR_STATUS, 7'd0, rd);
    check("status set beats clear", 32'(rd), 32'h10);
    core_done = 1'b0;
    repeat (4) @(negedge usb_clk);

    // Bank reset in the middle of a core_rst pulse with core_en set.
    do_write(ADDR_CTRL, 7'd0, 8'h06);
    check("mid-pulse core_en set", 32'(core_en), 32'd1);
    repeat (4) @(negedge usb_clk);
    check("mid-pulse core_rst at cycle 5", 32'(core_rst), 32'd1);
    rst = 1'b1;
    @(negedge usb_clk);
    check("rst drops core_rst", 32'(core_rst), 32'd0);
    check("rst clears core_en", 32'(core_en), 32'd0);
    check("rst clears reg_datao", 32'(reg_datao), 32'd0);
    rst = 1'b0;
    @(negedge usb_clk);
    do_read(ADDR_HSCOUNT, 7'd0, rd);
    check("rst clears hscount byte0", 32'(rd), 32'h00);
    do_read(ADDR_HSCOUNT, 7'd1, rd);
    check("rst clears hscount byte1", 32'(rd), 32'h00);
    check("rst clears core_cfg", core_cfg, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
